ttl_74x153_dual_mux: RTL and testbench
======================================

// Module: ttl_74x153_dual_mux
// PURPOSE
//   Behavioural model of a 74x153 dual 4-to-1 data selector/multiplexer for the TTL CPU library.
//   Two sections share the select inputs a/b; each section has its own active-low strobe.
//   Combinational by default; optional output register for synchronous use in the datapath.
//   The module has one clock and one reset. The reset is asynchronous and active-high.
// PARAMETERS
//   REGISTERED  0  0: y1/y2 are purely combinational; 1: y1/y2 are registered on rising clk
// PORTS
//   clk      in   1  clock (used only when REGISTERED=1)
//   rst      in   1  asynchronous, active-high reset
//   a        in   1  select LSB (datasheet A), shared by both sections
//   b        in   1  select MSB (datasheet B), shared by both sections
//   enable1  in   1  section-1 strobe (datasheet 1G), active low
//   enable2  in   1  section-2 strobe (datasheet 2G), active low
//   c10..c13 in   1  section-1 data inputs 0..3
//   c20..c23 in   1  section-2 data inputs 0..3
//   y1       out  1  section-1 output, true (non-inverted) data
//   y2       out  1  section-2 output, true (non-inverted) data
// BEHAVIOUR
//   - sel = {b,a}: 00->cX0, 01 (a=1,b=0)->cX1, 10 (a=0,b=1)->cX2, 11->cX3.
//   - y1 = enable1 ? 0 : c1[sel]; y2 = enable2 ? 0 : c2[sel].
//   - A disabled section drives 0. It never drives X or Z.
//   - Each strobe gates only its own section. Both strobes may be active or inactive together.
//   - Select and data changes are independent.
//   - REGISTERED=0:
//     - Outputs follow inputs within the same delta cycle. No latency. No state.
//     - clk is ignored. rst forces y1=y2=0 while rst=1.
//     - After rst falls, the outputs return to normal mux values.
//   - REGISTERED=1:
//     - On rising clk, y1/y2 are updated from the comb values above. Latency is 1 cycle.
//     - rst=1 clears y1=y2=0 immediately, asynchronously, and holds them at 0 while asserted.
//     - The first valid capture is the first rising clk after rst deasserts.
//     - If rst is asserted mid-operation, the previously captured values are discarded.
//   - Reset value of every output is 0.
//   - X/Z handling: a non-0/1 select or strobe produces X on the affected output in simulation.
//   - No gate delays are modelled.
// TESTING (REGISTERED=0, rst=0; apply stimulus, wait 50 time units, check outputs)
//   1. All inputs 0 -> y1=0, y2=0.
//      Then c10=1, a=b=0 -> y1=1, y2=0.
//   2. Walk select with c1 = 1,0,0,0 / 1,1,0,0 / 1,1,1,0 / 1,1,1,1 (c10..c13) and c2=0000.
//      - a=1,b=0 with c11=0 -> y1=0; with c11=1 -> y1=1.
//      - a=0,b=1 with c12=0/1 -> y1=0/1.
//      - a=1,b=1 with c13=0/1 -> y1=0/1.
//   3. Same walk on section 2 with c1=1111:
//      - c2 = 1000 and a=b=0 -> {y1,y2}=11.
//      - a=1,b=0, c2=1000 -> 10; c2=1100 -> 11.
//      - Repeat through c23 with a=b=1.
//   4. a=b=1, all data=1:
//      - enable1=enable2=1 -> 00.
//      - enable1=0, enable2=1 -> 10.
//      - enable1=1, enable2=0 -> 01.
//   5. rst=1 with all data=1, both strobes low -> 00.
//      Release rst -> 11.
//   6. REGISTERED=1: with all data=1, strobes low:
//      - y stays 00 until the first rising clk after reset, then 11.
//      - Assert rst between clock edges -> 00 without a clk edge.

Source files
------------

// File: rtl/ttl_74x153_dual_mux.sv
// ---------------------------------------------------------------------------
// ttl_74x153_dual_mux
//   Dual 4-to-1 data selector for the TTL CPU library.
//   Two sections share the select pair {b,a}. Each section has its own
//   active-low strobe, and a disabled section drives 0.
//   With REGISTERED=0 the outputs are combinational and rst forces them to 0.
//   With REGISTERED=1 the outputs are captured on rising clk. rst clears them
//   asynchronously and holds them at 0.
// ---------------------------------------------------------------------------
module ttl_74x153_dual_mux #(
  parameter int REGISTERED = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic enable1,
  input  logic enable2,
  input  logic c10,
  input  logic c11,
  input  logic c12,
  input  logic c13,
  input  logic c20,
  input  logic c21,
  input  logic c22,
  input  logic c23,
  output logic y1,
  output logic y2
);

  logic [1:0] sel;
  logic [3:0] c1_bus;
  logic [3:0] c2_bus;
  logic       mux1, mux2;
  logic       y1_d, y2_d;
  logic       y1_q, y2_q;

  assign sel    = {b, a};
  assign c1_bus = {c13, c12, c11, c10};
  assign c2_bus = {c23, c22, c21, c20};

  // Select one data bit per section. An unknown select propagates X in simulation.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (the default
    // arm included), otherwise synthesis infers a latch.
    case (sel)
      2'b00:   begin mux1 = c1_bus[0]; mux2 = c2_bus[0]; end
      2'b01:   begin mux1 = c1_bus[1]; mux2 = c2_bus[1]; end
      2'b10:   begin mux1 = c1_bus[2]; mux2 = c2_bus[2]; end
      2'b11:   begin mux1 = c1_bus[3]; mux2 = c2_bus[3]; end
      default: begin mux1 = 1'bx;      mux2 = 1'bx;      end
    endcase
  end

  // Gate each section with its own active-low strobe. A strobe that is
  // neither 0 nor 1 yields X, even when the selected data bit is 0.
  always_comb begin
    case (enable1)
      1'b0:    y1_d = mux1;
      1'b1:    y1_d = 1'b0;
      default: y1_d = 1'bx;
    endcase
    case (enable2)
      1'b0:    y2_d = mux2;
      1'b1:    y2_d = 1'b0;
      default: y2_d = 1'bx;
    endcase
  end

  // Optional output register. Reset clears any captured value immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments, so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      y1_q <= 1'b0;
      y2_q <= 1'b0;
    end else begin
      y1_q <= y1_d;
      y2_q <= y2_d;
    end
  end

  // The parameter picks the registered or the combinational path. The unused
  // path is removed at elaboration, and clk stays connected in both builds.
  assign y1 = (REGISTERED != 0) ? y1_q : (rst ? 1'b0 : y1_d);
  assign y2 = (REGISTERED != 0) ? y2_q : (rst ? 1'b0 : y2_d);

endmodule

// File: tb/tb_ttl_74x153_dual_mux.sv
// ---------------------------------------------------------------------------
// tb_ttl_74x153_dual_mux
//   Scoreboard bench. A combinational instance and a registered instance share
//   one set of inputs. Each cycle the stimulus process drives new inputs just
//   after the rising edge and pushes the expected outputs of both instances.
//   The monitor pops one entry at every falling edge and compares it.
// ---------------------------------------------------------------------------
module tb_ttl_74x153_dual_mux;

  typedef struct packed {
    logic       rst;
    logic       en1;
    logic       en2;
    logic       b;
    logic       a;
    logic [3:0] c1;   // {c13,c12,c11,c10}
    logic [3:0] c2;   // {c23,c22,c21,c20}
  } vec_t;

  typedef struct {
    int         idx;
    logic [1:0] exp_comb;  // {y1,y2} of the combinational instance
    logic [1:0] exp_reg;   // {y1,y2} of the registered instance
  } item_t;

  logic clk = 1'b0;
  logic rst, a, b, enable1, enable2;
  logic c10, c11, c12, c13, c20, c21, c22, c23;
  logic y1_c, y2_c, y1_r, y2_r;

  int    n_checks = 0;
  int    n_fail   = 0;
  item_t sb_q[$];
  bit    stim_done = 1'b0;

  // Model state for the registered instance: rst and the mux result seen at the latest edge.
  logic       prev_rst = 1'b1;
  logic [1:0] prev_ref = 2'b00;
  int         vec_idx  = 0;

  always #5 clk = ~clk;

  ttl_74x153_dual_mux #(.REGISTERED(0)) u_comb (
    .clk(clk), .rst(rst), .a(a), .b(b), .enable1(enable1), .enable2(enable2),
    .c10(c10), .c11(c11), .c12(c12), .c13(c13),
    .c20(c20), .c21(c21), .c22(c22), .c23(c23),
    .y1(y1_c), .y2(y2_c)
  );

  ttl_74x153_dual_mux #(.REGISTERED(1)) u_reg (
    .clk(clk), .rst(rst), .a(a), .b(b), .enable1(enable1), .enable2(enable2),
    .c10(c10), .c11(c11), .c12(c12), .c13(c13),
    .c20(c20), .c21(c21), .c22(c22), .c23(c23),
    .y1(y1_r), .y2(y2_r)
  );

  // Reference model: shift out the selected data bit. A high strobe forces 0.
  function automatic logic [1:0] ref_mux(input vec_t v);
    int  s;
    logic o1, o2;
    s  = 2 * int'(v.b) + int'(v.a);
    o1 = v.en1 ? 1'b0 : logic'((v.c1 >> s) & 4'd1);
    o2 = v.en2 ? 1'b0 : logic'((v.c2 >> s) & 4'd1);
    return {o1, o2};
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got y1y2=%b, expected %b", name, act, exp);
    end
  endtask

  // Drive one vector just after the rising edge and queue the expected results.
  // With use_exp set, the combinational expectation comes from exp_c instead of the model.
  task automatic apply(input vec_t v, input bit use_exp, input logic [1:0] exp_c);
    item_t it;
    @(posedge clk);
    #1;
    rst = v.rst; enable1 = v.en1; enable2 = v.en2; a = v.a; b = v.b;
    {c13, c12, c11, c10} = v.c1;
    {c23, c22, c21, c20} = v.c2;
    it.idx      = vec_idx++;
    it.exp_comb = v.rst ? 2'b00 : (use_exp ? exp_c : ref_mux(v));
    // Registered output: cleared while rst is high now, cleared if rst was high
    // at the last edge, otherwise it holds the previous vector's mux result.
    it.exp_reg  = (v.rst || prev_rst) ? 2'b00 : prev_ref;
    sb_q.push_back(it);
    prev_rst = v.rst;
    prev_ref = ref_mux(v);
  endtask

  function automatic vec_t mk(input logic r, input logic e1, input logic e2,
                              input logic bb, input logic aa,
                              input logic [3:0] d1, input logic [3:0] d2);
    vec_t v;
    v.rst = r; v.en1 = e1; v.en2 = e2; v.b = bb; v.a = aa; v.c1 = d1; v.c2 = d2;
    return v;
  endfunction

  // Stimulus: reset and first-capture sequence, directed walks, then random traffic.
  initial begin : stim
    vec_t v;
    rst = 1'b1; a = 1'b0; b = 1'b0; enable1 = 1'b0; enable2 = 1'b0;
    {c13, c12, c11, c10} = 4'hf;
    {c23, c22, c21, c20} = 4'hf;

    // Reset with all data 1 and both strobes low, then release and capture.
    apply(mk(1, 0, 0, 1, 1, 4'hf, 4'hf), 1, 2'b00);
    apply(mk(1, 0, 0, 1, 1, 4'hf, 4'hf), 1, 2'b00);
    apply(mk(0, 0, 0, 1, 1, 4'hf, 4'hf), 1, 2'b11);   // reg still 00
    apply(mk(0, 0, 0, 1, 1, 4'hf, 4'hf), 1, 2'b11);   // reg now 11
    apply(mk(1, 0, 0, 1, 1, 4'hf, 4'hf), 1, 2'b00);   // async clear between edges
    apply(mk(0, 0, 0, 1, 1, 4'hf, 4'hf), 1, 2'b11);

    // All zero, then c10.
    apply(mk(0, 0, 0, 0, 0, 4'b0000, 4'b0000), 1, 2'b00);
    apply(mk(0, 0, 0, 0, 0, 4'b0001, 4'b0000), 1, 2'b10);
    // Section-1 select walk.
    apply(mk(0, 0, 0, 0, 1, 4'b0001, 4'b0000), 1, 2'b00);
    apply(mk(0, 0, 0, 0, 1, 4'b0011, 4'b0000), 1, 2'b10);
    apply(mk(0, 0, 0, 1, 0, 4'b0011, 4'b0000), 1, 2'b00);
    apply(mk(0, 0, 0, 1, 0, 4'b0111, 4'b0000), 1, 2'b10);
    apply(mk(0, 0, 0, 1, 1, 4'b0111, 4'b0000), 1, 2'b00);
    apply(mk(0, 0, 0, 1, 1, 4'b1111, 4'b0000), 1, 2'b10);
    // Section-2 select walk with c1 = 1111.
    apply(mk(0, 0, 0, 0, 0, 4'b1111, 4'b0001), 1, 2'b11);
    apply(mk(0, 0, 0, 0, 1, 4'b1111, 4'b0001), 1, 2'b10);
    apply(mk(0, 0, 0, 0, 1, 4'b1111, 4'b0011), 1, 2'b11);
    apply(mk(0, 0, 0, 1, 0, 4'b1111, 4'b0011), 1, 2'b10);
    apply(mk(0, 0, 0, 1, 0, 4'b1111, 4'b0111), 1, 2'b11);
    apply(mk(0, 0, 0, 1, 1, 4'b1111, 4'b0111), 1, 2'b10);
    apply(mk(0, 0, 0, 1, 1, 4'b1111, 4'b1111), 1, 2'b11);
    // Strobes.
    apply(mk(0, 1, 1, 1, 1, 4'hf, 4'hf), 1, 2'b00);
    apply(mk(0, 0, 1, 1, 1, 4'hf, 4'hf), 1, 2'b10);
    apply(mk(0, 1, 0, 1, 1, 4'hf, 4'hf), 1, 2'b01);
    // Reset with data present, then release.
    apply(mk(1, 0, 0, 1, 1, 4'hf, 4'hf), 1, 2'b00);
    apply(mk(0, 0, 0, 1, 1, 4'hf, 4'hf), 1, 2'b11);

    // Random traffic with occasional mid-stream resets.
    for (int i = 0; i < 400; i++) begin
      v      = vec_t'($urandom);
      v.rst  = ($urandom_range(0, 15) == 0);
      v.en1  = ($urandom_range(0, 3) == 0);
      v.en2  = ($urandom_range(0, 3) == 0);
      apply(v, 0, 2'b00);
    end
    stim_done = 1'b1;
  end

  // Monitor: compare one queued expectation at each falling edge, bounded by a cycle budget.
  initial begin : mon
    item_t it;
    int    cycles = 0;
    int    idle   = 0;
    forever begin
      @(negedge clk);
      cycles++;
      if (sb_q.size() > 0) begin
        it   = sb_q.pop_front();
        idle = 0;
        check($sformatf("comb_vec%0d", it.idx), {y1_c, y2_c}, it.exp_comb);
        check($sformatf("reg_vec%0d",  it.idx), {y1_r, y2_r}, it.exp_reg);
      end else if (stim_done) begin
        break;
      end else begin
        idle++;
      end
      if (idle > 100 || cycles > 5000) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout: monitor waited %0d cycles, limit 5000", cycles);
        break;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
